regfile_param: RTL and testbench
================================

REGFILE_PARAM -- requirements
Module: regfile_param

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, bit width of each register entry.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5, address width; depth DEPTH = 2**ADDR_WIDTH entries.
REQ-003 SHALL have parameter ZERO_REG, default 1; 1 = entry 0 hardwired to zero, 0 = entry 0 is an ordinary register.
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 rst  input  1  synchronous active-high reset; starts the clear sequence.
REQ-007 rd_we  input  1  write enable.
REQ-008 rd_addr  input  ADDR_WIDTH  write address.
REQ-009 rd_data  input  DATA_WIDTH  write data.
REQ-010 rs1_addr  input  ADDR_WIDTH  read port 1 address.
REQ-011 rs2_addr  input  ADDR_WIDTH  read port 2 address.
REQ-012 stall  input  1  when 1, both read outputs hold their value.
REQ-013 rs1_data  output  DATA_WIDTH  registered read data, port 1.
REQ-014 rs2_data  output  DATA_WIDTH  registered read data, port 2.
REQ-015 busy  output  1  registered; 1 while the clear sequence runs.

Function
REQ-016 Reads SHALL have 1-cycle latency: rsN_data at edge k+1 reflects rsN_addr sampled at edge k.
REQ-017 With stall=1 and busy=0, rs1_data/rs2_data SHALL hold; array writes still proceed.
REQ-018 A write SHALL occur at the edge when rd_we=1, busy=0, rst=0, and not (ZERO_REG=1 and rd_addr=0).
REQ-019 With ZERO_REG=1, a read of address 0 SHALL return all zeros regardless of any write attempt.
REQ-020 The clear FSM SHALL have two states: IDLE (busy=0) and CLEAR (busy=1), with an ADDR_WIDTH-bit clear counter.
REQ-021 rst=1 at an edge SHALL set state CLEAR and counter 0 from any state, including mid-CLEAR (the sequence restarts).
REQ-022 In CLEAR with rst=0, each edge SHALL write zero to entry[counter] and increment the counter.
REQ-023 The edge that clears entry DEPTH-1 SHALL move the FSM to IDLE; busy is therefore 1 for exactly DEPTH cycles after rst deasserts.
REQ-024 While rst=1 or busy=1, rd_we SHALL be ignored and rsN_data SHALL be loaded with zero.
REQ-025 On the first edge with busy=0, reads SHALL resume normally and return zero for every entry not yet written.
REQ-026 A read and a write to the same non-zero address at the same edge SHALL follow REQ-036/REQ-037.

Reset
REQ-027 At an edge with rst=1: rs1_data=0, rs2_data=0, state=CLEAR, counter=0; busy=1 from that edge onward.
REQ-028 Array contents SHALL be defined only after the clear sequence completes; no initial-block initialisation is relied on.
REQ-029 rst SHALL take priority over stall, rd_we and the clear counter.

Configuration
REQ-030 The macro REGFILE_BYPASS_EN SHALL control write-to-read forwarding.
REQ-031 Macro defined: same-edge write to the read address (REQ-018 true) SHALL forward rd_data to that rsN_data.
REQ-032 Macro undefined: such a read SHALL return the pre-write value (read-before-write).
REQ-033 The macro SHALL NOT affect ZERO_REG, stall or clear behaviour.
REQ-034 Forwarding SHALL apply independently to each read port.
REQ-035 Both builds SHALL have identical port lists.
REQ-036 Bypass build: same-address read/write returns the new data one cycle later.
REQ-037 Non-bypass build: same-address read/write returns the old data; new data is visible on the next read.

Verification
REQ-038 rst 1 cycle -> busy=1 for exactly 32 cycles, then reads of all 32 addresses return 0x00000000.
REQ-039 Write 0xDEADBEEF to addr 5, then rs1_addr=5 -> rs1_data=0xDEADBEEF one edge after the address is sampled; rs2 reads addr 5 concurrently with the same result.
REQ-040 ZERO_REG=1: write 0x12345678 to addr 0 -> read 0x00000000; ZERO_REG=0 -> read 0x12345678.
REQ-041 addr 7 holds 0x1111; write 0x2222 to addr 7 while rs1_addr=7 -> bypass build 0x2222, non-bypass 0x1111, 0x2222 on the next cycle.
REQ-042 Write 0xAAAA to addr 3 while busy=1 -> read of addr 3 after clear returns 0; rst reasserted at counter=10 -> busy stays 1 for 32 further cycles.
REQ-043 stall=1 for 3 cycles while rs1_addr changes 1->2->3 -> rs1_data holds its pre-stall value; updates on the first edge after stall drops.

Source files
------------

// File: rtl/regfile_param.sv
// Parameterised register file: two registered read ports, one write port, and a
// self-clearing reset sequence. Define REGFILE_BYPASS_EN for write-to-read forwarding.
module regfile_param #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int ZERO_REG   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_we,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  input  logic [ADDR_WIDTH-1:0] rs1_addr,
  input  logic [ADDR_WIDTH-1:0] rs2_addr,
  input  logic                  stall,
  output logic [DATA_WIDTH-1:0] rs1_data,
  output logic [DATA_WIDTH-1:0] rs2_data,
  output logic                  busy
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t                state;
  state_t                next_state;
  logic [ADDR_WIDTH-1:0] clr_cnt;
  logic [ADDR_WIDTH-1:0] next_cnt;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  wr_en;
  logic                  clr_en;
  logic [DATA_WIDTH-1:0] rd1_val;
  logic [DATA_WIDTH-1:0] rd2_val;

  // Reset restarts the clear sequence from entry 0, even mid-clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      clr_cnt <= '0;
    end else begin
      state   <= next_state;
      clr_cnt <= next_cnt;
    end
  end

  always_comb begin
    next_state = state;
    next_cnt   = clr_cnt;
    if (state == CLEAR) begin
      next_cnt = clr_cnt + 1'b1;
      if (clr_cnt == {ADDR_WIDTH{1'b1}}) begin
        next_state = IDLE;
      end
    end
  end

  always_comb begin
    busy   = (state == CLEAR);
    clr_en = (state == CLEAR) && !rst;
    wr_en  = rd_we && !rst && (state == IDLE)
             && !((ZERO_REG != 0) && (rd_addr == '0));
  end

  // The array itself is never reset; the clear sequence defines its contents.
  always_ff @(posedge clk) begin
    if (clr_en) begin
      mem[clr_cnt] <= '0;
    end else if (wr_en) begin
      mem[rd_addr] <= rd_data;
    end
  end

  always_comb begin
    rd1_val = mem[rs1_addr];
    rd2_val = mem[rs2_addr];
`ifdef REGFILE_BYPASS_EN
    if (wr_en && (rd_addr == rs1_addr)) begin
      rd1_val = rd_data;
    end
    if (wr_en && (rd_addr == rs2_addr)) begin
      rd2_val = rd_data;
    end
`endif
    if ((ZERO_REG != 0) && (rs1_addr == '0)) begin
      rd1_val = '0;
    end
    if ((ZERO_REG != 0) && (rs2_addr == '0)) begin
      rd2_val = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || busy) begin
      rs1_data <= '0;
      rs2_data <= '0;
    end else if (!stall) begin
      rs1_data <= rd1_val;
      rs2_data <= rd2_val;
    end
  end

endmodule

// File: tb/tb_regfile_param.sv
// Scoreboard bench for regfile_param: drives a ZERO_REG=1 and a ZERO_REG=0 instance
// in lockstep against a behavioural model, plus directed checks of key scenarios.
module tb_regfile_param;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rd_we = 1'b0;
  logic        stall = 1'b0;
  logic [4:0]  rd_addr = '0;
  logic [4:0]  rs1_addr = '0;
  logic [4:0]  rs2_addr = '0;
  logic [31:0] rd_data = '0;
  logic [31:0] rs1_a, rs2_a, rs1_b, rs2_b;
  logic        busy_a, busy_b;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    logic [31:0] a1;
    logic [31:0] a2;
    logic [31:0] b1;
    logic [31:0] b2;
    logic        busy;
  } exp_t;

  exp_t sb[$];
  int tests = 0;
  int fails = 0;

  logic [31:0] mem_z [32];
  logic [31:0] mem_n [32];
  logic        m_clear = 1'b0;
  int          m_cnt = 0;
  logic [31:0] e_a1 = '0, e_a2 = '0, e_b1 = '0, e_b2 = '0;

  regfile_param #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst), .rd_we(rd_we), .rd_addr(rd_addr), .rd_data(rd_data),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .stall(stall),
    .rs1_data(rs1_a), .rs2_data(rs2_a), .busy(busy_a)
  );

  regfile_param #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(0)) dut_nz (
    .clk(clk), .rst(rst), .rd_we(rd_we), .rd_addr(rd_addr), .rd_data(rd_data),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .stall(stall),
    .rs1_data(rs1_b), .rs2_data(rs2_b), .busy(busy_b)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle, predict the post-edge outputs, then compare after the edge.
  task automatic applyStimulus(input logic r, input logic we, input logic [4:0] wa,
                               input logic [31:0] wd, input logic [4:0] a1,
                               input logic [4:0] a2, input logic st);
    exp_t e;
    logic we_z, we_n;
    rst = r; rd_we = we; rd_addr = wa; rd_data = wd;
    rs1_addr = a1; rs2_addr = a2; stall = st;
    we_z = we && !r && !m_clear && (wa != 5'd0);
    we_n = we && !r && !m_clear;
    if (r || m_clear) begin
      e_a1 = '0; e_a2 = '0; e_b1 = '0; e_b2 = '0;
    end else if (!st) begin
      e_a1 = (a1 == 5'd0) ? 32'd0 : (BYP && we_z && wa == a1) ? wd : mem_z[a1];
      e_a2 = (a2 == 5'd0) ? 32'd0 : (BYP && we_z && wa == a2) ? wd : mem_z[a2];
      e_b1 = (BYP && we_n && wa == a1) ? wd : mem_n[a1];
      e_b2 = (BYP && we_n && wa == a2) ? wd : mem_n[a2];
    end
    if (r) begin
      m_clear = 1'b1;
      m_cnt   = 0;
    end else if (m_clear) begin
      mem_z[m_cnt] = '0;
      mem_n[m_cnt] = '0;
      if (m_cnt == 31) m_clear = 1'b0;
      m_cnt++;
    end else begin
      if (we_z) mem_z[wa] = wd;
      if (we_n) mem_n[wa] = wd;
    end
    sb.push_back('{e_a1, e_a2, e_b1, e_b2, m_clear});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    checkOutput("sb_rs1_z", rs1_a, e.a1);
    checkOutput("sb_rs2_z", rs2_a, e.a2);
    checkOutput("sb_rs1_nz", rs1_b, e.b1);
    checkOutput("sb_rs2_nz", rs2_b, e.b2);
    checkOutput("sb_busy", {31'd0, busy_a}, {31'd0, e.busy});
    checkOutput("sb_busy_nz", {31'd0, busy_b}, {31'd0, e.busy});
  endtask

  task automatic countBusy(output int n);
    n = 0;
    do begin
      applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0);
      n++;
    end while (busy_a && n < 100);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    for (int i = 0; i < 32; i++) begin
      mem_z[i] = '0;
      mem_n[i] = '0;
    end
    @(negedge clk);

    applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0);
    checkOutput("rst_busy", {31'd0, busy_a}, 32'd1);
    checkOutput("rst_rs1", rs1_a, 32'd0);
    countBusy(n);
    checkOutput("busy_len_init", n, 32'd32);
    for (int i = 0; i < 32; i++) begin
      applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 5'(i), 5'(31 - i), 1'b0);
      checkOutput("clr_rs1", rs1_a, 32'd0);
      checkOutput("clr_rs2_nz", rs2_b, 32'd0);
    end

    applyStimulus(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0, 1'b0);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 5'd5, 5'd5, 1'b0);
    checkOutput("rd5_rs1", rs1_a, 32'hDEADBEEF);
    checkOutput("rd5_rs2", rs2_a, 32'hDEADBEEF);

    applyStimulus(1'b0, 1'b1, 5'd0, 32'h12345678, 5'd1, 5'd1, 1'b0);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0);
    checkOutput("zero_reg1", rs1_a, 32'd0);
    checkOutput("zero_reg0", rs1_b, 32'h12345678);

    applyStimulus(1'b0, 1'b1, 5'd7, 32'h1111, 5'd0, 5'd0, 1'b0);
    applyStimulus(1'b0, 1'b1, 5'd7, 32'h2222, 5'd7, 5'd7, 1'b0);
    checkOutput("raw_same_edge", rs1_a, BYP ? 32'h2222 : 32'h1111);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 5'd7, 5'd7, 1'b0);
    checkOutput("raw_next", rs1_a, 32'h2222);

    applyStimulus(1'b0, 1'b1, 5'd1, 32'h101, 5'd0, 5'd0, 1'b0);
    applyStimulus(1'b0, 1'b1, 5'd2, 32'h202, 5'd0, 5'd0, 1'b0);
    applyStimulus(1'b0, 1'b1, 5'd3, 32'h303, 5'd0, 5'd0, 1'b0);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 5'd5, 5'd5, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      applyStimulus(1'b0, k == 2, 5'd4, 32'h404, 5'(k), 5'(k), 1'b1);
      checkOutput("stall_hold", rs1_a, 32'hDEADBEEF);
    end
    applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 5'd3, 5'd4, 1'b0);
    checkOutput("stall_release", rs1_a, 32'h303);
    checkOutput("stall_write", rs2_a, 32'h404);

    applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0);
    applyStimulus(1'b0, 1'b1, 5'd3, 32'hAAAA, 5'd3, 5'd3, 1'b0);
    checkOutput("busy_read", rs1_a, 32'd0);
    for (int k = 0; k < 9; k++) applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0);
    checkOutput("busy_mid", {31'd0, busy_a}, 32'd1);
    applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0);
    countBusy(n);
    checkOutput("busy_len_restart", n, 32'd32);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 5'd3, 5'd3, 1'b0);
    checkOutput("busy_write_ignored", rs1_a, 32'd0);

    for (int c = 0; c < 300; c++) begin
      applyStimulus($urandom_range(0, 149) == 0, $urandom_range(0, 1) == 1,
                    5'($urandom_range(0, 31)), $urandom,
                    5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                    $urandom_range(0, 3) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
